// File: rtl/div_real_seq_if.sv
// div_real_seq_if: operand/result valid-ready bundle for div_real_seq.
interface div_real_seq_if #(parameter int a_width = 1, b_width = 1, c_width = 1);
  logic signed [a_width-1:0] a;
  logic signed [b_width-1:0] b;
  logic                      in_valid;
  logic                      in_ready;
  logic signed [c_width-1:0] c;
  logic                      out_valid;
  logic                      out_ready;
  logic                      div_by_zero;
  modport master(output a, b, in_valid, out_ready, input in_ready, c, out_valid, div_by_zero);
  modport slave(input a, b, in_valid, out_ready, output in_ready, c, out_valid, div_by_zero);
endinterface

// File: rtl/div_real_seq.sv
// div_real_seq: sequential signed fixed-point divider c = a / b, one quotient bit per clk.
// DIV_REAL_ROUND_EN selects round-half-away-from-zero instead of truncation toward zero.
module div_real_seq #(
  parameter int a_width = 1,
  parameter int a_exponent = 0,
  parameter int b_width = 1,
  parameter int b_exponent = 0,
  parameter int c_width = 1,
  parameter int c_exponent = 0
) (
  input logic clk,
  input logic rst,
  div_real_seq_if.slave bus
);
  localparam int S = a_exponent - b_exponent - c_exponent;
  localparam int SP = S > 0 ? S : 0;
  localparam int SN = S < 0 ? -S : 0;
  localparam int NW = a_width + SP;
  localparam int DW = b_width + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;
  logic [a_width:0] a_mag;
  logic [NW:0] a_ext;
  logic [DW-1:0] b_mag, d, rem;
  logic [DW:0] rem_sh;
  logic take, a_neg, neg;
`ifdef DIV_REAL_ROUND_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int QW = NW + RB;
  localparam int CW = $clog2(QW) + 1;
  localparam int MW = (QW > c_width ? QW : c_width) + 1;
  logic [QW-1:0] nq;
  logic [CW-1:0] cnt;
  logic [MW-1:0] q, lim;
  logic [c_width-1:0] c_max, c_min, c_nxt;
  assign a_mag = bus.a[a_width-1] ? -{bus.a[a_width-1], bus.a} : {bus.a[a_width-1], bus.a};
  assign b_mag = bus.b[b_width-1] ? -{bus.b[b_width-1], bus.b} : {bus.b[b_width-1], bus.b};
  assign a_ext = (NW+1)'(a_mag);
  // nq starts as the dividend and fills with quotient bits as dividend bits shift out
  assign rem_sh = {rem, nq[QW-1]};
  assign take = rem_sh >= {1'b0, d};
`ifdef DIV_REAL_ROUND_EN
  assign q = MW'(nq >> 1) + MW'(nq[0]);
`else
  assign q = MW'(nq);
`endif
  assign lim = MW'(1) << (c_width - 1);
  assign c_max = c_width'(lim - MW'(1));
  assign c_min = c_width'(lim);
  always_comb begin
    c_nxt = d == '0 ? (a_neg ? c_min : c_max)
          : neg ? (q > lim ? c_min : c_width'(-q))
          : (q >= lim ? c_max : c_width'(q));
  end
  always_comb begin
    state_nxt = state == IDLE ? (bus.in_valid ? CALC : IDLE)
              : state == CALC ? (cnt == '0 ? FIX : CALC)
              : state == FIX  ? DONE
              : (bus.out_ready ? IDLE : DONE);
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      nq <= '0;
      d <= '0;
      rem <= '0;
      cnt <= '0;
      a_neg <= 1'b0;
      neg <= 1'b0;
      bus.c <= '0;
      bus.div_by_zero <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      nq <= QW'(NW'((a_ext << SP) >> SN)) << RB;
      d <= b_mag;
      rem <= '0;
      cnt <= CW'(QW - 1);
      a_neg <= bus.a[a_width-1];
      neg <= bus.a[a_width-1] ^ bus.b[b_width-1];
    end else if (state == CALC) begin
      rem <= DW'(take ? rem_sh - {1'b0, d} : rem_sh);
      nq <= QW'({nq, take});
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      bus.c <= c_nxt;
      bus.div_by_zero <= d == '0;
    end
endmodule
